// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment read-back path: active-low segment
// patterns (bit0=a .. bit6=g) and the capture FSM state encoding.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h18;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_D_ALT = 7'h61;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    SETTLE = 2'd1,
    LOCKED = 2'd2
  } cap_state_e;

  // Bring a raw bus into the active-low domain the decode table is written in.
  function automatic logic [6:0] seg_to_active_low(input logic [6:0] raw,
                                                   input logic       active_low);
    return active_low ? raw : ~raw;
  endfunction

endpackage

// File: rtl/seg7_digit_dec.sv
// Inverse of the hex display encoder: one active-low segment pattern back to
// its nibble, flagging any pattern the encoder never produces.
module seg7_digit_dec
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] nibble,
  output logic       legal
);

  always_comb begin
    nibble = 4'h0;
    legal  = 1'b1;
    case (seg)
      SEG_0:     nibble = 4'h0;
      SEG_1:     nibble = 4'h1;
      SEG_2:     nibble = 4'h2;
      SEG_3:     nibble = 4'h3;
      SEG_4:     nibble = 4'h4;
      SEG_5:     nibble = 4'h5;
      SEG_6:     nibble = 4'h6;
      SEG_7:     nibble = 4'h7;
      SEG_8:     nibble = 4'h8;
      SEG_9:     nibble = 4'h9;
      SEG_A:     nibble = 4'hA;
      SEG_B:     nibble = 4'hB;
      SEG_C:     nibble = 4'hC;
      SEG_D:     nibble = 4'hD;
      SEG_D_ALT: nibble = 4'hD;
      SEG_E:     nibble = 4'hE;
      SEG_F:     nibble = 4'hF;
      default: begin
        nibble = 4'h0;
        legal  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/seg7_capture.sv
// Recovers the 8-bit value shown on a two-digit 7-segment bus, committing a
// reading only after STABLE_CNT identical legal samples in a row.
module seg7_capture
  import seg7_pkg::*;
#(
  parameter int STABLE_CNT = 3,
  parameter bit SEG_INV    = 1'b1
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       sample_en,
  input  logic [6:0] hex1,
  input  logic [6:0] hex0,
  output logic [7:0] value,
  output logic       valid,
  output logic       upd,
  output logic       err
);

  localparam int                STAB_W   = $clog2(STABLE_CNT + 1);
  localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_CNT);
  localparam logic [STAB_W-1:0] STAB_ONE = STAB_W'(1);

  logic [6:0] seg1, seg0;
  logic [3:0] nib1, nib0;
  logic       legal1, legal0;
  logic [7:0] sample_pat;
  logic       sample_legal;

  cap_state_e        state_q, state_d;
  logic [7:0]        value_q, value_d;
  logic              valid_q, valid_d;
  logic              upd_q, upd_d;
  logic              err_q, err_d;
  logic [7:0]        cand_q, cand_d;
  logic [STAB_W-1:0] stab_q, stab_d;

  assign seg1 = seg_to_active_low(hex1, SEG_INV);
  assign seg0 = seg_to_active_low(hex0, SEG_INV);

  seg7_digit_dec u_dec1 (
    .seg    (seg1),
    .nibble (nib1),
    .legal  (legal1)
  );

  seg7_digit_dec u_dec0 (
    .seg    (seg0),
    .nibble (nib0),
    .legal  (legal0)
  );

  assign sample_pat   = {nib1, nib0};
  assign sample_legal = legal1 & legal0;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= EMPTY;
      value_q <= 8'h00;
      valid_q <= 1'b0;
      upd_q   <= 1'b0;
      err_q   <= 1'b0;
      cand_q  <= 8'h00;
      stab_q  <= '0;
    end else begin
      state_q <= state_d;
      value_q <= value_d;
      valid_q <= valid_d;
      upd_q   <= upd_d;
      err_q   <= err_d;
      cand_q  <= cand_d;
      stab_q  <= stab_d;
    end
  end

  // Commit is judged on the post-update stab/cand so the value appears the
  // cycle right after the STABLE_CNT-th matching strobe.
  always_comb begin
    state_d = state_q;
    value_d = value_q;
    valid_d = valid_q;
    cand_d  = cand_q;
    stab_d  = stab_q;
    upd_d   = 1'b0;
    err_d   = 1'b0;

    if (sample_en) begin
      if (!sample_legal) begin
        err_d = 1'b1;
        stab_d = '0;
        if (state_q == EMPTY || !valid_q) begin
          state_d = EMPTY;
        end else begin
          state_d = LOCKED;
        end
      end else begin
        if (sample_pat == cand_q && stab_q != '0) begin
          stab_d = (stab_q == STAB_MAX) ? STAB_MAX : stab_q + STAB_ONE;
        end else begin
          cand_d = sample_pat;
          stab_d = STAB_ONE;
        end

        if (stab_d == STAB_MAX && (!valid_q || cand_d != value_q)) begin
          value_d = cand_d;
          valid_d = 1'b1;
          upd_d   = 1'b1;
          state_d = LOCKED;
        end else if (valid_q && cand_d == value_q) begin
          state_d = LOCKED;
        end else begin
          state_d = SETTLE;
        end
      end
    end
  end

  assign value = value_q;
  assign valid = valid_q;
  assign upd   = upd_q;
  assign err   = err_q;

endmodule

// File: tb/tb_seg7_capture.sv
// Directed bench for seg7_capture: a vector table for the single-cycle
// behaviour plus hand-written reset, settle, sweep and polarity sequences.
module tb_seg7_capture;

  logic       clk = 1'b0;
  logic       clr;
  logic       sample_en;
  logic [6:0] hex1, hex0;
  logic [6:0] hex1_inv, hex0_inv;

  logic [7:0] value, value_inv, value_one;
  logic       valid, valid_inv, valid_one;
  logic       upd, upd_inv, upd_one;
  logic       err, err_inv, err_one;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign hex1_inv = ~hex1;
  assign hex0_inv = ~hex0;

  seg7_capture #(.STABLE_CNT(3), .SEG_INV(1'b1)) dut (
    .clk(clk), .clr(clr), .sample_en(sample_en), .hex1(hex1), .hex0(hex0),
    .value(value), .valid(valid), .upd(upd), .err(err)
  );

  seg7_capture #(.STABLE_CNT(3), .SEG_INV(1'b0)) dut_inv (
    .clk(clk), .clr(clr), .sample_en(sample_en), .hex1(hex1_inv), .hex0(hex0_inv),
    .value(value_inv), .valid(valid_inv), .upd(upd_inv), .err(err_inv)
  );

  seg7_capture #(.STABLE_CNT(1), .SEG_INV(1'b1)) dut_one (
    .clk(clk), .clr(clr), .sample_en(sample_en), .hex1(hex1), .hex0(hex0),
    .value(value_one), .valid(valid_one), .upd(upd_one), .err(err_one)
  );

  typedef struct {
    logic       en;
    logic [6:0] h1;
    logic [6:0] h0;
    logic [7:0] value;
    logic       valid;
    logic       upd;
    logic       err;
    logic [7:0] one_value;
    logic       one_upd;
  } vec_t;

  vec_t       vecs [24];
  logic [6:0] enc  [16];

  task automatic check_output(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive on the falling edge, then return 1 time unit after the rising edge.
  task automatic apply_stimulus(input logic en, input logic [6:0] h1, input logic [6:0] h0);
    @(negedge clk);
    sample_en = en;
    hex1      = h1;
    hex0      = h0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int upd_cnt;
    int err_cnt;
    int inv_err_cnt;

    enc[0]  = 7'h40; enc[1]  = 7'h79; enc[2]  = 7'h24; enc[3]  = 7'h30;
    enc[4]  = 7'h19; enc[5]  = 7'h12; enc[6]  = 7'h02; enc[7]  = 7'h78;
    enc[8]  = 7'h00; enc[9]  = 7'h18; enc[10] = 7'h08; enc[11] = 7'h03;
    enc[12] = 7'h46; enc[13] = 7'h21; enc[14] = 7'h06; enc[15] = 7'h0E;

    //          en    h1     h0     value  vld   upd   err   one_v  one_upd
    vecs[0]  = '{1'b1, 7'h79, 7'h24, 8'h00, 1'b0, 1'b0, 1'b0, 8'h12, 1'b1};
    vecs[1]  = '{1'b1, 7'h79, 7'h24, 8'h00, 1'b0, 1'b0, 1'b0, 8'h12, 1'b0};
    vecs[2]  = '{1'b1, 7'h79, 7'h24, 8'h12, 1'b1, 1'b1, 1'b0, 8'h12, 1'b0};
    vecs[3]  = '{1'b0, 7'h79, 7'h24, 8'h12, 1'b1, 1'b0, 1'b0, 8'h12, 1'b0};
    vecs[4]  = '{1'b1, 7'h79, 7'h24, 8'h12, 1'b1, 1'b0, 1'b0, 8'h12, 1'b0};
    vecs[5]  = '{1'b1, 7'h79, 7'h24, 8'h12, 1'b1, 1'b0, 1'b0, 8'h12, 1'b0};
    vecs[6]  = '{1'b1, 7'h79, 7'h30, 8'h12, 1'b1, 1'b0, 1'b0, 8'h13, 1'b1};
    vecs[7]  = '{1'b1, 7'h79, 7'h30, 8'h12, 1'b1, 1'b0, 1'b0, 8'h13, 1'b0};
    vecs[8]  = '{1'b1, 7'h79, 7'h24, 8'h12, 1'b1, 1'b0, 1'b0, 8'h12, 1'b1};
    vecs[9]  = '{1'b1, 7'h79, 7'h30, 8'h12, 1'b1, 1'b0, 1'b0, 8'h13, 1'b1};
    vecs[10] = '{1'b1, 7'h79, 7'h30, 8'h12, 1'b1, 1'b0, 1'b0, 8'h13, 1'b0};
    vecs[11] = '{1'b1, 7'h79, 7'h30, 8'h13, 1'b1, 1'b1, 1'b0, 8'h13, 1'b0};
    vecs[12] = '{1'b1, 7'h30, 7'h08, 8'h13, 1'b1, 1'b0, 1'b0, 8'h3A, 1'b1};
    vecs[13] = '{1'b1, 7'h30, 7'h08, 8'h13, 1'b1, 1'b0, 1'b0, 8'h3A, 1'b0};
    vecs[14] = '{1'b1, 7'h30, 7'h7F, 8'h13, 1'b1, 1'b0, 1'b1, 8'h3A, 1'b0};
    vecs[15] = '{1'b1, 7'h30, 7'h08, 8'h13, 1'b1, 1'b0, 1'b0, 8'h3A, 1'b0};
    vecs[16] = '{1'b1, 7'h30, 7'h08, 8'h13, 1'b1, 1'b0, 1'b0, 8'h3A, 1'b0};
    vecs[17] = '{1'b1, 7'h30, 7'h08, 8'h3A, 1'b1, 1'b1, 1'b0, 8'h3A, 1'b0};
    vecs[18] = '{1'b0, 7'h30, 7'h08, 8'h3A, 1'b1, 1'b0, 1'b0, 8'h3A, 1'b0};
    vecs[19] = '{1'b1, 7'h40, 7'h61, 8'h3A, 1'b1, 1'b0, 1'b0, 8'h0D, 1'b1};
    vecs[20] = '{1'b1, 7'h40, 7'h61, 8'h3A, 1'b1, 1'b0, 1'b0, 8'h0D, 1'b0};
    vecs[21] = '{1'b1, 7'h40, 7'h61, 8'h0D, 1'b1, 1'b1, 1'b0, 8'h0D, 1'b0};
    vecs[22] = '{1'b0, 7'h7F, 7'h7F, 8'h0D, 1'b1, 1'b0, 1'b0, 8'h0D, 1'b0};
    vecs[23] = '{1'b1, 7'h7F, 7'h40, 8'h0D, 1'b1, 1'b0, 1'b1, 8'h0D, 1'b0};

    clr       = 1'b1;
    sample_en = 1'b0;
    hex1      = 7'h40;
    hex0      = 7'h40;
    repeat (2) @(negedge clk);
    check_output("reset_value", value, 8'h00);
    check_output("reset_valid", 8'(valid), 8'h00);
    check_output("reset_upd",   8'(upd),   8'h00);
    check_output("reset_err",   8'(err),   8'h00);
    clr = 1'b0;

    for (int i = 0; i < 24; i++) begin
      apply_stimulus(vecs[i].en, vecs[i].h1, vecs[i].h0);
      check_output($sformatf("v%0d_value", i), value, vecs[i].value);
      check_output($sformatf("v%0d_valid", i), 8'(valid), 8'(vecs[i].valid));
      check_output($sformatf("v%0d_upd", i),   8'(upd),   8'(vecs[i].upd));
      check_output($sformatf("v%0d_err", i),   8'(err),   8'(vecs[i].err));
      check_output($sformatf("v%0d_inv_value", i), value_inv, vecs[i].value);
      check_output($sformatf("v%0d_inv_upd", i),   8'(upd_inv), 8'(vecs[i].upd));
      check_output($sformatf("v%0d_inv_err", i),   8'(err_inv), 8'(vecs[i].err));
      check_output($sformatf("v%0d_one_value", i), value_one, vecs[i].one_value);
      check_output($sformatf("v%0d_one_upd", i),   8'(upd_one), 8'(vecs[i].one_upd));
    end

    // Asynchronous clear while err is high: outputs drop without a clock edge.
    #2;
    clr = 1'b1;
    #1;
    check_output("async_clr_value", value, 8'h00);
    check_output("async_clr_valid", 8'(valid), 8'h00);
    check_output("async_clr_err",   8'(err),   8'h00);
    check_output("async_clr_upd",   8'(upd),   8'h00);

    apply_stimulus(1'b1, 7'h79, 7'h24);
    check_output("clr_ignores_strobe_valid", 8'(valid), 8'h00);
    @(negedge clk);
    clr       = 1'b0;
    sample_en = 1'b0;

    // Clear in the middle of settling throws away the two matching samples.
    apply_stimulus(1'b1, 7'h79, 7'h24);
    apply_stimulus(1'b1, 7'h79, 7'h24);
    #1 clr = 1'b1;
    #1 clr = 1'b0;
    apply_stimulus(1'b1, 7'h79, 7'h24);
    apply_stimulus(1'b1, 7'h79, 7'h24);
    check_output("midsettle_not_committed", 8'(valid), 8'h00);
    apply_stimulus(1'b1, 7'h79, 7'h24);
    check_output("midsettle_commit_value", value, 8'h12);
    check_output("midsettle_commit_upd",   8'(upd), 8'h01);

    upd_cnt     = 0;
    err_cnt     = 0;
    inv_err_cnt = 0;
    for (int v = 0; v < 256; v++) begin
      for (int k = 0; k < 3; k++) begin
        apply_stimulus(1'b1, enc[v / 16], enc[v % 16]);
        if (upd) upd_cnt++;
        if (err) err_cnt++;
        if (err_inv) inv_err_cnt++;
      end
      check_output($sformatf("sweep_%02h", v), value, 8'(v));
    end
    check_output("sweep_upd_count", 8'(upd_cnt == 256), 8'h01);
    check_output("sweep_err_count", 8'(err_cnt), 8'h00);
    check_output("sweep_inv_err_count", 8'(inv_err_cnt), 8'h00);
    check_output("sweep_inv_value", value_inv, 8'hFF);

    // Active-high bus {79,3F} on the SEG_INV=0 instance reads back as E0.
    repeat (3) apply_stimulus(1'b1, 7'h06, 7'h40);
    check_output("inv_bus_hex1", 8'(hex1_inv), 8'h79);
    check_output("inv_bus_hex0", 8'(hex0_inv), 8'h3F);
    check_output("inv_value_E0", value_inv, 8'hE0);
    check_output("inv_err_E0",   8'(err_inv), 8'h00);
    check_output("main_value_E0", value, 8'hE0);
    apply_stimulus(1'b0, 7'h06, 7'h40);
    check_output("inv_upd_falls", 8'(upd_inv), 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
